// File: rtl/pe_pkg.sv
// Shared constants and helpers for the weight-stationary processing element.
package pe_pkg;

  localparam int ERR_SKEW       = 0;
  localparam int ERR_EMPTY_SWAP = 1;
  localparam int LIMIT_W        = 64;

  // Clamp limits for a psum of the given width, returned sign-extended to LIMIT_W bits
  // so that the low `width` bits are the limit itself.
  function automatic logic [LIMIT_W-1:0] sat_limit(input int width, input bit is_signed,
                                                   input bit want_max);
    logic [LIMIT_W-1:0] r;
    r = '0;
    if (want_max) begin
      for (int i = 0; i < LIMIT_W; i++)
        if (i < width - (is_signed ? 1 : 0)) r[i] = 1'b1;
    end else if (is_signed) begin
      for (int i = 0; i < LIMIT_W; i++)
        if (i >= width - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_ws_db_mac.sv
// Combinational multiply-accumulate with overflow detection and optional clamp.
module pe_mac
  import pe_pkg::*;
#(
  parameter int ACT_WIDTH  = 8,
  parameter int WGT_WIDTH  = 8,
  parameter int PSUM_WIDTH = 32,
  parameter int SIGNED     = 0,
  parameter int SATURATE   = 0
) (
  input  logic [ACT_WIDTH-1:0]  a_i,
  input  logic [WGT_WIDTH-1:0]  w_i,
  input  logic [PSUM_WIDTH-1:0] p_i,
  input  logic                  p_en_i,
  output logic [PSUM_WIDTH-1:0] sum_o,
  output logic                  ovf_o
);

  localparam int PW = PSUM_WIDTH;
  localparam logic [PW-1:0] PMAX = PW'(sat_limit(PW, SIGNED != 0, 1'b1));
  localparam logic [PW-1:0] PMIN = PW'(sat_limit(PW, SIGNED != 0, 1'b0));

  function automatic logic [PW-1:0] clamp(input logic [PW-1:0] wrapped, input logic ovf,
                                          input logic neg);
    if (SATURATE != 0 && ovf) return neg ? PMIN : PMAX;
    return wrapped;
  endfunction

  logic signed [PW-1:0] a_ext, w_ext, prod, addend;
  logic        [PW:0]   raw;

  always_comb begin
    if (SIGNED != 0) begin
      a_ext = PW'($signed(a_i));
      w_ext = PW'($signed(w_i));
    end else begin
      a_ext = PW'($unsigned(a_i));
      w_ext = PW'($unsigned(w_i));
    end
    // PSUM_WIDTH >= ACT+WGT, so the truncated product is exact in either signedness.
    prod   = a_ext * w_ext;
    addend = p_en_i ? p_i : '0;
    raw    = {1'b0, prod} + {1'b0, addend};
    if (SIGNED != 0)
      ovf_o = (prod[PW-1] == addend[PW-1]) && (raw[PW-1] != prod[PW-1]);
    else
      ovf_o = raw[PW];
    sum_o = clamp(raw[PW-1:0], ovf_o, (SIGNED != 0) && prod[PW-1]);
  end

endmodule

// File: rtl/pe_ws_db.sv
// Weight-stationary PE: shadow weight shifts down the column, swap token promotes it.
module pe_ws_db
  import pe_pkg::*;
#(
  parameter int ACT_WIDTH  = 8,
  parameter int WGT_WIDTH  = 8,
  parameter int PSUM_WIDTH = 32,
  parameter int SIGNED     = 0,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  err_clr,
  input  logic [ACT_WIDTH-1:0]  a_in,
  input  logic                  a_valid_in,
  output logic [ACT_WIDTH-1:0]  a_out,
  output logic                  a_valid_out,
  input  logic [WGT_WIDTH-1:0]  w_in,
  input  logic                  w_valid_in,
  output logic [WGT_WIDTH-1:0]  w_out,
  output logic                  w_valid_out,
  input  logic                  w_swap_in,
  output logic                  w_swap_out,
  input  logic [PSUM_WIDTH-1:0] p_in,
  input  logic                  p_valid_in,
  output logic [PSUM_WIDTH-1:0] p_out,
  output logic                  p_valid_out,
  output logic [WGT_WIDTH-1:0]  w_active,
  output logic [1:0]            err,
  output logic                  ovf
);

  logic [WGT_WIDTH-1:0]  active_q, active_d, shadow_q, shadow_d, w_out_q, w_out_d;
  logic                  shadow_full_q, shadow_full_d, w_vld_q, w_vld_d;
  logic [ACT_WIDTH-1:0]  a_out_q;
  logic                  a_vld_q, swap_q;
  logic [PSUM_WIDTH-1:0] p_out_q, p_out_d, mac_sum;
  logic                  p_vld_q, p_vld_d, mac_ovf;
  logic [1:0]            err_q, err_d;
  logic                  ovf_q, ovf_d;

  // The MAC always sees the pre-swap weight; a swap only takes effect next cycle.
  pe_mac #(
    .ACT_WIDTH (ACT_WIDTH),
    .WGT_WIDTH (WGT_WIDTH),
    .PSUM_WIDTH(PSUM_WIDTH),
    .SIGNED    (SIGNED),
    .SATURATE  (SATURATE)
  ) u_mac (
    .a_i   (a_in),
    .w_i   (active_q),
    .p_i   (p_in),
    .p_en_i(p_valid_in),
    .sum_o (mac_sum),
    .ovf_o (mac_ovf)
  );

  always_comb begin
    active_d      = active_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    w_out_d       = w_out_q;
    w_vld_d       = 1'b0;
    p_out_d       = p_out_q;
    p_vld_d       = 1'b0;
    err_d         = err_clr ? 2'b00 : err_q;
    ovf_d         = err_clr ? 1'b0 : ovf_q;

    if (w_valid_in) begin
      shadow_d      = w_in;
      shadow_full_d = 1'b1;
      w_out_d       = shadow_q;
      w_vld_d       = shadow_full_q;
    end

    if (w_swap_in) begin
      if (shadow_full_q) begin
        active_d = shadow_q;
        if (!w_valid_in) shadow_full_d = 1'b0;
      end else begin
        err_d[ERR_EMPTY_SWAP] = 1'b1;
      end
    end

    if (a_valid_in) begin
      p_out_d = mac_sum;
      p_vld_d = 1'b1;
      if (mac_ovf) ovf_d = 1'b1;
    end else if (p_valid_in) begin
      p_out_d         = p_in;
      p_vld_d         = 1'b1;
      err_d[ERR_SKEW] = 1'b1;
    end
  end

  // ---- register stage: all outputs are one cycle after their inputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q      <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      w_out_q       <= '0;
      w_vld_q       <= 1'b0;
      a_out_q       <= '0;
      a_vld_q       <= 1'b0;
      swap_q        <= 1'b0;
      p_out_q       <= '0;
      p_vld_q       <= 1'b0;
      err_q         <= 2'b00;
      ovf_q         <= 1'b0;
    end else begin
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      w_out_q       <= w_out_d;
      w_vld_q       <= w_vld_d;
      a_out_q       <= a_in;
      a_vld_q       <= a_valid_in;
      swap_q        <= w_swap_in;
      p_out_q       <= p_out_d;
      p_vld_q       <= p_vld_d;
      err_q         <= err_d;
      ovf_q         <= ovf_d;
    end
  end

  assign a_out       = a_out_q;
  assign a_valid_out = a_vld_q;
  assign w_out       = w_out_q;
  assign w_valid_out = w_vld_q;
  assign w_swap_out  = swap_q;
  assign p_out       = p_out_q;
  assign p_valid_out = p_vld_q;
  assign w_active    = active_q;
  assign err         = err_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_pe_ws_db.sv
// Directed bench: 3-cell unsigned column plus two 16-bit signed cells (clamp / wrap).
module tb_pe_ws_db;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, err_clr;

  // Unsigned 3-cell column
  logic [7:0]  w_top;
  logic        wv_top;
  logic [31:0] p_top;
  logic        pv_top;
  logic [7:0]  a_c[3];
  logic        av_c[3], sw_c[3];
  logic [7:0]  a_o[3], w_o[3], wa[3];
  logic        av_o[3], wv_o[3], swo[3], pv_o[3], ov[3];
  logic [31:0] p_o[3];
  logic [1:0]  er[3];

  // Signed 16-bit cells sharing one stimulus
  logic [7:0]  s_a, s_w;
  logic        s_av, s_wv, s_sw, s_pv;
  logic [15:0] s_p;
  logic [7:0]  sat_ao, sat_wo, sat_wa, wrp_ao, wrp_wo, wrp_wa;
  logic        sat_avo, sat_wvo, sat_swo, sat_pvo, sat_ov;
  logic        wrp_avo, wrp_wvo, wrp_swo, wrp_pvo, wrp_ov;
  logic [15:0] sat_po, wrp_po;
  logic [1:0]  sat_er, wrp_er;

  int err_cnt = 0;
  int chk_cnt = 0;

  pe_ws_db c0 (.clk(clk), .reset(reset), .err_clr(err_clr),
    .a_in(a_c[0]), .a_valid_in(av_c[0]), .a_out(a_o[0]), .a_valid_out(av_o[0]),
    .w_in(w_top), .w_valid_in(wv_top), .w_out(w_o[0]), .w_valid_out(wv_o[0]),
    .w_swap_in(sw_c[0]), .w_swap_out(swo[0]),
    .p_in(p_top), .p_valid_in(pv_top), .p_out(p_o[0]), .p_valid_out(pv_o[0]),
    .w_active(wa[0]), .err(er[0]), .ovf(ov[0]));

  pe_ws_db c1 (.clk(clk), .reset(reset), .err_clr(err_clr),
    .a_in(a_c[1]), .a_valid_in(av_c[1]), .a_out(a_o[1]), .a_valid_out(av_o[1]),
    .w_in(w_o[0]), .w_valid_in(wv_o[0]), .w_out(w_o[1]), .w_valid_out(wv_o[1]),
    .w_swap_in(sw_c[1]), .w_swap_out(swo[1]),
    .p_in(p_o[0]), .p_valid_in(pv_o[0]), .p_out(p_o[1]), .p_valid_out(pv_o[1]),
    .w_active(wa[1]), .err(er[1]), .ovf(ov[1]));

  pe_ws_db c2 (.clk(clk), .reset(reset), .err_clr(err_clr),
    .a_in(a_c[2]), .a_valid_in(av_c[2]), .a_out(a_o[2]), .a_valid_out(av_o[2]),
    .w_in(w_o[1]), .w_valid_in(wv_o[1]), .w_out(w_o[2]), .w_valid_out(wv_o[2]),
    .w_swap_in(sw_c[2]), .w_swap_out(swo[2]),
    .p_in(p_o[1]), .p_valid_in(pv_o[1]), .p_out(p_o[2]), .p_valid_out(pv_o[2]),
    .w_active(wa[2]), .err(er[2]), .ovf(ov[2]));

  pe_ws_db #(.ACT_WIDTH(8), .WGT_WIDTH(8), .PSUM_WIDTH(16), .SIGNED(1), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .err_clr(err_clr),
    .a_in(s_a), .a_valid_in(s_av), .a_out(sat_ao), .a_valid_out(sat_avo),
    .w_in(s_w), .w_valid_in(s_wv), .w_out(sat_wo), .w_valid_out(sat_wvo),
    .w_swap_in(s_sw), .w_swap_out(sat_swo),
    .p_in(s_p), .p_valid_in(s_pv), .p_out(sat_po), .p_valid_out(sat_pvo),
    .w_active(sat_wa), .err(sat_er), .ovf(sat_ov));

  pe_ws_db #(.ACT_WIDTH(8), .WGT_WIDTH(8), .PSUM_WIDTH(16), .SIGNED(1), .SATURATE(0)) u_wrp (
    .clk(clk), .reset(reset), .err_clr(err_clr),
    .a_in(s_a), .a_valid_in(s_av), .a_out(wrp_ao), .a_valid_out(wrp_avo),
    .w_in(s_w), .w_valid_in(s_wv), .w_out(wrp_wo), .w_valid_out(wrp_wvo),
    .w_swap_in(s_sw), .w_swap_out(wrp_swo),
    .p_in(s_p), .p_valid_in(s_pv), .p_out(wrp_po), .p_valid_out(wrp_pvo),
    .w_active(wrp_wa), .err(wrp_er), .ovf(wrp_ov));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; err_clr = 1'b0;
    w_top = '0; wv_top = 1'b0; p_top = '0; pv_top = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_c[i] = '0; av_c[i] = 1'b0; sw_c[i] = 1'b0;
    end
    s_a = '0; s_w = '0; s_av = 1'b0; s_wv = 1'b0; s_sw = 1'b0; s_p = '0; s_pv = 1'b0;

    // Reset state
    step();
    check("rst_p_out",  p_o[0], 32'd0);
    check("rst_p_vld",  32'(pv_o[0]), 32'd0);
    check("rst_w_act",  32'(wa[2]), 32'd0);
    check("rst_w_vld",  32'(wv_o[2]), 32'd0);
    check("rst_err",    32'(er[0]), 32'd0);
    check("rst_ovf",    32'(sat_ov), 32'd0);
    reset = 1'b0;

    // 1. Column load 5,6,7 then swap; skewed a=2 gives 36 at the bottom
    wv_top = 1'b1; w_top = 8'd5; step();
    w_top = 8'd6; step();
    w_top = 8'd7; step();
    wv_top = 1'b0; step();
    step();
    for (int i = 0; i < 3; i++) sw_c[i] = 1'b1;
    step();
    for (int i = 0; i < 3; i++) sw_c[i] = 1'b0;
    check("col_act0", 32'(wa[0]), 32'd7);
    check("col_act1", 32'(wa[1]), 32'd6);
    check("col_act2", 32'(wa[2]), 32'd5);
    check("col_swap_out", 32'(swo[2]), 32'd1);
    a_c[0] = 8'd2; av_c[0] = 1'b1; step();
    check("col_p0", p_o[0], 32'd14);
    check("col_a_out", 32'(a_o[0]), 32'd2);
    av_c[0] = 1'b0; a_c[0] = '0; a_c[1] = 8'd2; av_c[1] = 1'b1; step();
    check("col_p1", p_o[1], 32'd26);
    av_c[1] = 1'b0; a_c[1] = '0; a_c[2] = 8'd2; av_c[2] = 1'b1; step();
    check("col_p2", p_o[2], 32'd36);
    check("col_p2_vld", 32'(pv_o[2]), 32'd1);
    av_c[2] = 1'b0; a_c[2] = '0;
    check("col_err2", 32'(er[2]), 32'd0);

    // 2. Double-buffer overlap on the top cell: active=4, shadow=9
    w_top = 8'd4; wv_top = 1'b1; step();
    wv_top = 1'b0; sw_c[0] = 1'b1; step();
    sw_c[0] = 1'b0;
    check("db_act4", 32'(wa[0]), 32'd4);
    a_c[0] = 8'd3; av_c[0] = 1'b1; p_top = 32'd10; pv_top = 1'b1;
    w_top = 8'd9; wv_top = 1'b1; step();
    check("db_p_load", p_o[0], 32'd22);
    wv_top = 1'b0; step();
    check("db_p_hold", p_o[0], 32'd22);
    sw_c[0] = 1'b1; step();
    check("db_p_swap_edge", p_o[0], 32'd22);
    check("db_act9", 32'(wa[0]), 32'd9);
    sw_c[0] = 1'b0; step();
    check("db_p_after", p_o[0], 32'd37);
    av_c[0] = 1'b0; a_c[0] = '0; pv_top = 1'b0; p_top = '0;

    // 3. Simultaneous swap and load
    w_top = 8'd8; wv_top = 1'b1; step();
    w_top = 8'd1; sw_c[0] = 1'b1; step();
    sw_c[0] = 1'b0;
    check("sim_act8", 32'(wa[0]), 32'd8);
    check("sim_err", 32'(er[0]), 32'd0);
    w_top = 8'd2; step();
    check("sim_shadow1", 32'(w_o[0]), 32'd1);
    check("sim_full", 32'(wv_o[0]), 32'd1);
    wv_top = 1'b0; sw_c[0] = 1'b1; step();
    check("sim_act2", 32'(wa[0]), 32'd2);
    check("sim_err2", 32'(er[0]), 32'd0);

    // 4. Error flags
    step();
    sw_c[0] = 1'b0;
    check("empty_swap_err", 32'(er[0]), 32'd2);
    check("empty_swap_act", 32'(wa[0]), 32'd2);
    p_top = 32'd55; pv_top = 1'b1; step();
    check("skew_p_out", p_o[0], 32'd55);
    check("skew_p_vld", 32'(pv_o[0]), 32'd1);
    check("skew_err", 32'(er[0]), 32'd3);
    pv_top = 1'b0; p_top = '0; step();
    check("bubble_p_vld", 32'(pv_o[0]), 32'd0);
    check("bubble_p_hold", p_o[0], 32'd55);
    err_clr = 1'b1; sw_c[0] = 1'b1; step();
    check("clr_vs_err", 32'(er[0]), 32'd2);
    sw_c[0] = 1'b0; step();
    check("clr_err", 32'(er[0]), 32'd0);
    err_clr = 1'b0;

    // 5. Signed saturation vs wrap, PSUM_WIDTH=16
    s_w = 8'd3; s_wv = 1'b1; step();
    s_wv = 1'b0; s_sw = 1'b1; step();
    s_sw = 1'b0;
    check("s_act", 32'(sat_wa), 32'd3);
    s_a = 8'd4; s_av = 1'b1; s_p = 16'd32760; s_pv = 1'b1; step();
    check("sat_pos", 32'(sat_po), 32'h7FFF);
    check("sat_pos_ovf", 32'(sat_ov), 32'd1);
    check("wrp_pos", 32'(wrp_po), 32'h8004);
    check("wrp_pos_ovf", 32'(wrp_ov), 32'd1);
    s_a = 8'hFC; s_p = 16'h8008; step();
    check("sat_neg", 32'(sat_po), 32'h8000);
    check("wrp_neg", 32'(wrp_po), 32'h7FFC);
    s_a = 8'hFE; s_p = 16'd100; step();
    check("sat_noovf", 32'(sat_po), 32'd94);
    check("wrp_noovf", 32'(wrp_po), 32'd94);
    s_av = 1'b0; s_pv = 1'b0; s_a = '0; s_p = '0;

    // 6. Reset in the middle of a load and a stream
    w_top = 8'd3; wv_top = 1'b1; a_c[0] = 8'd5; av_c[0] = 1'b1; step();
    reset = 1'b1; step();
    check("mid_rst_p", p_o[0], 32'd0);
    check("mid_rst_pv", 32'(pv_o[0]), 32'd0);
    check("mid_rst_a", 32'(a_o[0]), 32'd0);
    check("mid_rst_av", 32'(av_o[0]), 32'd0);
    check("mid_rst_wact", 32'(wa[0]), 32'd0);
    check("mid_rst_wv", 32'(wv_o[0]), 32'd0);
    check("mid_rst_ovf", 32'(sat_ov), 32'd0);
    reset = 1'b0; wv_top = 1'b0; w_top = '0; av_c[0] = 1'b0; a_c[0] = '0;
    sw_c[0] = 1'b1; step();
    sw_c[0] = 1'b0;
    check("post_rst_swap_err", 32'(er[0]), 32'd2);
    check("post_rst_wact", 32'(wa[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pe_ws_db.md
# pe_ws_db

Parametrised weight-stationary processing element with a double-buffered weight register. It is the next-generation cell for the systolic array.
- Weights for the next tile shift down the column into a shadow register while the current tile computes; a swap token then promotes them.
- Operand widths, signedness and saturation are parameters.
- Every stream carries a valid bit, so bubbles and skew errors are handled explicitly.

## Interface
- ACT_WIDTH, 8, activation width
- WGT_WIDTH, 8, weight width
- PSUM_WIDTH, 32, partial-sum width; must be >= ACT_WIDTH+WGT_WIDTH
- SIGNED, 0, 1 = two's-complement operands and psum, 0 = unsigned
- SATURATE, 0, 1 = clamp psum on overflow, 0 = wrap
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- err_clr  in  1  clears sticky err/ovf flags
- a_in / a_valid_in  in  ACT_WIDTH / 1  activation from left neighbour
- a_out / a_valid_out  out  ACT_WIDTH / 1  activation to right neighbour
- w_in / w_valid_in  in  WGT_WIDTH / 1  weight shift chain from above
- w_out / w_valid_out  out  WGT_WIDTH / 1  weight shift chain to below
- w_swap_in  in  1  swap token from left neighbour
- w_swap_out  out  1  swap token to right neighbour
- p_in / p_valid_in  in  PSUM_WIDTH / 1  partial sum from above; the top row ties both to 0
- p_out / p_valid_out  out  PSUM_WIDTH / 1  partial sum to below
- w_active  out  WGT_WIDTH  current active weight (debug/verification)
- err  out  2  sticky flags: [0] psum-without-activation skew, [1] swap with empty shadow
- ovf  out  1  sticky psum overflow

## Operation
**State:**
- active, shadow, shadow_full
- a, p and w output registers
- err, ovf

**Weight load:**
- Condition: w_valid_in=1.
- Actions: shadow<=w_in; shadow_full<=1; w_out<=shadow (old value); w_valid_out<=shadow_full (old value).
- Effect: a column of N cells loads its N weights in N cycles; the first weight entered lands in the bottom cell.

**Swap:**
- Condition: w_swap_in=1 and shadow_full=1.
- Actions: active<=shadow; shadow_full<=0.
- Empty shadow: if shadow_full=0, active is unchanged and err[1]<=1.
- Token forwarding: w_swap_out<=w_swap_in in every case.
- Simultaneous swap and load:
  - active takes the old shadow;
  - shadow takes w_in;
  - shadow_full stays 1.

**Compute:**
- prod = a_in*active, with SIGNED extension to PSUM_WIDTH.
- sum = prod + (p_valid_in ? p_in : 0).
- Same-cycle swap: a product in the same cycle as a swap uses the pre-swap active weight.

**Registered outputs:**
- a_out<=a_in; a_valid_out<=a_valid_in.
- If a_valid_in: p_out<=sum_sat_or_wrap; p_valid_out<=1.
- Else if p_valid_in:
  - p_out<=p_in (pass-through), p_valid_out<=1;
  - err[0]<=1.
- Else: p_valid_out<=0 and p_out holds its value.

**Overflow detection:**
- Unsigned: carry out of PSUM_WIDTH.
- Signed: operands have the same sign and the result sign differs.
- On overflow, ovf<=1 regardless of SATURATE.
- With SATURATE=1 the result clamps to the max/min of PSUM_WIDTH.

**err_clr:** clears err and ovf. If an error occurs in the same cycle, the error wins.

## Timing
**Reset:**
- Zeroes every register: active, shadow, shadow_full, a_out, a_valid_out, w_out, w_valid_out, w_swap_out, p_out, p_valid_out, err, ovf.
- All outputs therefore read 0 the cycle after reset. Reset mid-load or mid-compute discards all state.

**Latency, all fixed at 1 cycle:**
- a_in to a_out.
- p_in/a_in to p_out.
- w_in to w_out.
- w_swap_in to w_swap_out.
- A swap at edge k makes the new weight visible on w_active and in the products from cycle k+1.

**Stalls:** none. There is no backpressure; the array controller guarantees skew.

**Throughput:** one MAC per cycle per cell.

## Structure
- Package pe_pkg holds:
  - err bit index constants ERR_SKEW=0 and ERR_EMPTY_SWAP=1;
  - a function returning saturation max/min for a given width and signedness.
- Sub-module pe_mac: combinational multiply plus add with overflow detect and optional clamp, parametrised identically.
- The top cell holds all registers and the weight/swap control.
- Expected size: about 200 lines total.

## Test plan
1. **Load and compute:** 3-cell column chain, w_in 5,6,7 on consecutive cycles, then a swap.
   - Expect active = 7,6,5 top to bottom.
   - With a_in=2 skewed and p_in=0 at the top, the bottom cell's p_out is 2·7+2·6+2·5 = 36.
2. **Double-buffer overlap:** load shadow=9 while streaming a_in=3, p_in=10 against active=4.
   - p_out stays 22 until the swap.
   - The cycle after the swap edge, the same inputs give 37.
3. **Simultaneous swap and load:** shadow=8, then w_swap_in and w_valid_in(w_in=1) in the same cycle.
   - Expect active=8, shadow=1, shadow_full=1, err=0.
4. **Error flags:**
   - Swap with an empty shadow: err[1]=1 and active is unchanged.
   - p_valid_in=1, a_valid_in=0, p_in=55: p_out=55, p_valid_out=1, err[0]=1.
   - err_clr: the next cycle err=0.
5. **Signed saturation:** SIGNED=1, SATURATE=1, PSUM_WIDTH=16, p_in=32760, a_in=4, active=3.
   - Expect p_out=32767 and ovf=1.
   - Same stimulus with SATURATE=0: p_out=-32764 and ovf=1.
6. **Reset mid-operation:** assert reset during a load and an active stream.
   - The next cycle all outputs are 0 and shadow_full=0.
   - A subsequent swap sets err[1].
